// File: rtl/syn_co_arb_pkg.sv
// Shared types and helpers for the round-robin counter arbiter:
// FSM state encoding, default sizes and the round-robin winner search.
package syn_co_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 3;
    localparam int MAX_NREQ  = 8;
    localparam int RR_IDW    = 3;

    // Before the first grant the search starts at requester 0; afterwards it
    // starts one past the last winner. Result is only meaningful when req != 0.
    function automatic logic [RR_IDW-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [RR_IDW-1:0]   last,
        input logic                fresh,
        input int                  nreq
    );
        int                start;
        int                idx;
        logic              found;
        logic [RR_IDW-1:0] win;
        start = fresh ? 0 : (int'(last) + 1) % nreq;
        found = 1'b0;
        win   = last;
        for (int k = 0; k < MAX_NREQ; k++) begin
            idx = (start + k) % nreq;
            if (k < nreq && !found && req[idx]) begin
                win   = RR_IDW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/syn_co_arb_if.sv
// Request/grant/counter bundle between the event sources (master) and
// the shared-counter arbiter (slave).
interface syn_co_arb_if
    import syn_co_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IDW = $clog2(NREQ);

    logic              clr;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   dir;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_id;
    logic              busy;
    logic              wrap;
    logic [WIDTH-1:0]  count;

    modport master (
        output clr, req, dir,
        input  gnt, gnt_id, busy, wrap, count
    );

    modport slave (
        input  clr, req, dir,
        output gnt, gnt_id, busy, wrap, count
    );

endinterface

// File: rtl/syn_co_arb_updn_cnt.sv
// WIDTH-bit up/down counter with modulo or saturating limits; wrap_evt
// pulses for one cycle after a step that wrapped or was blocked.
module updn_cnt #(
    parameter int WIDTH = 3,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             wrap_evt
);
    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_limit;

    // clr wins over a pending step: the step is dropped and no event is flagged.
    always_comb begin
        at_limit = up ? (count_q == MAXV) : (count_q == '0);
        count_d  = count_q;
        wrap_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            wrap_d = at_limit;
            if (!(SAT && at_limit)) begin
                count_d = up ? (count_q + ONE) : (count_q - ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count    = count_q;
    assign wrap_evt = wrap_q;

endmodule

// File: rtl/syn_co_arb.sv
// Round-robin arbiter sharing one up/down counter among NREQ requesters;
// each grant runs a fixed IDLE -> STEP -> HOLD sequence.
module syn_co_arb
    import syn_co_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter bit SAT   = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    syn_co_arb_if.slave    bus
);
    localparam int IDW = $clog2(NREQ);

    arb_state_e        state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [IDW-1:0]    gnt_id_q;
    logic [IDW-1:0]    ptr_q;
    logic              first_q;
    logic              dir_q;

    logic [IDW-1:0]    win_id_d;
    logic [NREQ-1:0]   win_onehot_d;
    logic              cnt_en;
    logic              wrap_evt;
    logic [WIDTH-1:0]  count;

    assign win_id_d = IDW'(rr_pick(MAX_NREQ'(bus.req), RR_IDW'(ptr_q), first_q, NREQ));

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign win_onehot_d[gi] = (win_id_d == IDW'(gi));
    end

    // The pointer only advances once the step is issued, so a request that is
    // still high after HOLD competes again from the next position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            first_q  <= 1'b1;
            dir_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_q    <= win_onehot_d;
                        gnt_id_q <= win_id_d;
                        dir_q    <= bus.dir[win_id_d];
                        state_q  <= STEP;
                    end
                end
                STEP: begin
                    gnt_q   <= '0;
                    ptr_q   <= gnt_id_q;
                    first_q <= 1'b0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cnt_en = (state_q == STEP);

    updn_cnt #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.clr),
        .en       (cnt_en),
        .up       (dir_q),
        .count    (count),
        .wrap_evt (wrap_evt)
    );

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.wrap   = wrap_evt;
    assign bus.count  = count;

    gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

endmodule

// File: tb/tb_syn_co_arb.sv
// Bench for syn_co_arb: a modulo and a saturating instance driven with the
// same stimulus, checked against vector tables, corner sequences and a model.
module tb_syn_co_arb;
    import syn_co_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_v = '0;
    logic [3:0] dir_v = '0;
    logic       clr_v = 1'b0;

    syn_co_arb_if #(.NREQ(4), .WIDTH(3)) if0 ();
    syn_co_arb_if #(.NREQ(4), .WIDTH(3)) if1 ();

    assign if0.req = req_v;
    assign if0.dir = dir_v;
    assign if0.clr = clr_v;
    assign if1.req = req_v;
    assign if1.dir = dir_v;
    assign if1.clr = clr_v;

    syn_co_arb #(.NREQ(4), .WIDTH(3), .SAT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    syn_co_arb #(.NREQ(4), .WIDTH(3), .SAT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Transaction-level reference: phase counter, last winner, integer count.
    int         m_cnt [2];
    bit         m_wrap[2];
    int         m_phase;
    int         m_last;
    int         m_win;
    bit         m_fresh;
    bit         m_dir;
    logic [3:0] m_gnt;

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_cnt[s]  = 0;
            m_wrap[s] = 1'b0;
        end
        m_phase = 0;
        m_last  = 0;
        m_win   = 0;
        m_fresh = 1'b1;
        m_dir   = 1'b0;
        m_gnt   = '0;
    endtask

    task automatic model_edge();
        int n;
        int start;
        bit found;
        for (int s = 0; s < 2; s++) begin
            m_wrap[s] = 1'b0;
            if (clr_v) begin
                m_cnt[s] = 0;
            end else if (m_phase == 1) begin
                n = m_cnt[s] + (m_dir ? 1 : -1);
                if (n > 7 || n < 0) begin
                    m_wrap[s] = 1'b1;
                    if (s == 1) m_cnt[s] = (n > 7) ? 7 : 0;
                    else        m_cnt[s] = (n + 8) % 8;
                end else begin
                    m_cnt[s] = n;
                end
            end
        end
        case (m_phase)
            0: begin
                if (req_v != 0) begin
                    start = m_fresh ? 0 : (m_last + 1) % 4;
                    found = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        if (!found && req_v[(start + k) % 4]) begin
                            m_win = (start + k) % 4;
                            found = 1'b1;
                        end
                    end
                    m_dir   = dir_v[m_win];
                    m_gnt   = 4'b0001 << m_win;
                    m_phase = 1;
                end
            end
            1: begin
                m_gnt   = '0;
                m_last  = m_win;
                m_fresh = 1'b0;
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        if (if0.gnt != 0)
            $display("txn t=%0t gnt=%b id=%0d dir=%0b count0=%0d count1=%0d",
                     $time, if0.gnt, if0.gnt_id, req_v[if0.gnt_id] ? dir_v[if0.gnt_id] : 1'b0,
                     if0.count, if1.count);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_v = '0;
        dir_v = '0;
        clr_v = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_model(input int cyc);
        chk($sformatf("rnd%0d gnt0", cyc),   32'(if0.gnt),    32'(m_gnt));
        chk($sformatf("rnd%0d gnt1", cyc),   32'(if1.gnt),    32'(m_gnt));
        chk($sformatf("rnd%0d id", cyc),     32'(if0.gnt_id), 32'(m_win));
        chk($sformatf("rnd%0d busy", cyc),   32'(if0.busy),   32'(m_phase != 0));
        chk($sformatf("rnd%0d count0", cyc), 32'(if0.count),  32'(m_cnt[0]));
        chk($sformatf("rnd%0d count1", cyc), 32'(if1.count),  32'(m_cnt[1]));
        chk($sformatf("rnd%0d wrap0", cyc),  32'(if0.wrap),   32'(m_wrap[0]));
        chk($sformatf("rnd%0d wrap1", cyc),  32'(if1.wrap),   32'(m_wrap[1]));
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] dir;
        logic       clr;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic [2:0] cnt0;
        logic       wrap0;
        logic [2:0] cnt1;
        logic       wrap1;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] rq, input logic [3:0] dr, input logic cl,
                                input logic [3:0] g, input logic [1:0] id, input logic b,
                                input logic [2:0] c0, input logic w0,
                                input logic [2:0] c1, input logic w1);
        vec_t v;
        v = '{req: rq, dir: dr, clr: cl, gnt: g, id: id, busy: b,
              cnt0: c0, wrap0: w0, cnt1: c1, wrap1: w1};
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        //   req    dir    clr  gnt    id busy c0 w0 c1 w1
        add(4'h1, 4'h1, 0, 4'h1, 0, 1, 0, 0, 0, 0);
        add(4'h1, 4'h1, 0, 4'h0, 0, 1, 1, 0, 1, 0);
        add(4'h1, 4'h1, 0, 4'h0, 0, 0, 1, 0, 1, 0);
        add(4'h1, 4'h1, 0, 4'h1, 0, 1, 1, 0, 1, 0);
        add(4'h1, 4'h1, 0, 4'h0, 0, 1, 2, 0, 2, 0);
        add(4'h1, 4'h1, 0, 4'h0, 0, 0, 2, 0, 2, 0);
        add(4'h1, 4'h1, 0, 4'h1, 0, 1, 2, 0, 2, 0);
        add(4'h1, 4'h1, 0, 4'h0, 0, 1, 3, 0, 3, 0);
        add(4'h1, 4'h1, 0, 4'h0, 0, 0, 3, 0, 3, 0);
        add(4'hF, 4'hF, 0, 4'h2, 1, 1, 3, 0, 3, 0);
        add(4'hF, 4'hF, 0, 4'h0, 1, 1, 4, 0, 4, 0);
        add(4'hF, 4'hF, 0, 4'h0, 1, 0, 4, 0, 4, 0);
        add(4'hF, 4'hF, 0, 4'h4, 2, 1, 4, 0, 4, 0);
        add(4'hF, 4'hF, 0, 4'h0, 2, 1, 5, 0, 5, 0);
        add(4'hF, 4'hF, 0, 4'h0, 2, 0, 5, 0, 5, 0);
        add(4'hF, 4'hF, 0, 4'h8, 3, 1, 5, 0, 5, 0);
        add(4'hF, 4'hF, 0, 4'h0, 3, 1, 6, 0, 6, 0);
        add(4'hF, 4'hF, 0, 4'h0, 3, 0, 6, 0, 6, 0);
        add(4'hF, 4'hF, 0, 4'h1, 0, 1, 6, 0, 6, 0);
        add(4'hF, 4'hF, 0, 4'h0, 0, 1, 7, 0, 7, 0);
        add(4'hF, 4'hF, 0, 4'h0, 0, 0, 7, 0, 7, 0);
        add(4'h4, 4'h4, 0, 4'h4, 2, 1, 7, 0, 7, 0);
        add(4'h4, 4'h4, 0, 4'h0, 2, 1, 0, 1, 7, 1);
        add(4'h4, 4'h4, 0, 4'h0, 2, 0, 0, 0, 7, 0);
        add(4'h2, 4'h0, 0, 4'h2, 1, 1, 0, 0, 7, 0);
        add(4'h2, 4'h0, 0, 4'h0, 1, 1, 7, 1, 6, 0);
        add(4'h2, 4'h0, 0, 4'h0, 1, 0, 7, 0, 6, 0);

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst count0", 32'(if0.count),  0);
        chk("rst count1", 32'(if1.count),  0);
        chk("rst gnt",    32'(if0.gnt),    0);
        chk("rst id",     32'(if0.gnt_id), 0);
        chk("rst busy",   32'(if0.busy),   0);
        chk("rst wrap",   32'(if0.wrap),   0);
        rst_n = 1'b1;

        // Vector table
        foreach (vecs[i]) begin
            req_v = vecs[i].req;
            dir_v = vecs[i].dir;
            clr_v = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d gnt", i),   32'(if0.gnt),    32'(vecs[i].gnt));
            chk($sformatf("vec%0d id", i),    32'(if0.gnt_id), 32'(vecs[i].id));
            chk($sformatf("vec%0d busy", i),  32'(if0.busy),   32'(vecs[i].busy));
            chk($sformatf("vec%0d count0", i), 32'(if0.count), 32'(vecs[i].cnt0));
            chk($sformatf("vec%0d wrap0", i), 32'(if0.wrap),   32'(vecs[i].wrap0));
            chk($sformatf("vec%0d count1", i), 32'(if1.count), 32'(vecs[i].cnt1));
            chk($sformatf("vec%0d wrap1", i), 32'(if1.wrap),   32'(vecs[i].wrap1));
        end

        // Down step at 0: modulo wraps to 7, saturating holds at 0
        do_reset();
        req_v = 4'h1;
        dir_v = 4'h0;
        tick();
        tick();
        chk("sat0 count0", 32'(if0.count), 7);
        chk("sat0 wrap0",  32'(if0.wrap),  1);
        chk("sat0 count1", 32'(if1.count), 0);
        chk("sat0 wrap1",  32'(if1.wrap),  1);
        req_v = 4'h0;
        tick();
        chk("sat0 wrap1 end", 32'(if1.wrap), 0);
        chk("sat0 busy end",  32'(if1.busy), 0);

        // clr in the STEP cycle of an up step from 5
        do_reset();
        req_v = 4'h1;
        dir_v = 4'h1;
        repeat (15) tick();
        chk("clr pre count", 32'(if0.count), 5);
        tick();
        chk("clr gnt", 32'(if0.gnt), 1);
        clr_v = 1'b1;
        req_v = 4'h0;
        tick();
        chk("clr count0", 32'(if0.count), 0);
        chk("clr count1", 32'(if1.count), 0);
        chk("clr wrap0",  32'(if0.wrap),  0);
        chk("clr gnt off", 32'(if0.gnt),  0);
        chk("clr busy",   32'(if0.busy),  1);
        clr_v = 1'b0;
        tick();
        chk("clr idle", 32'(if0.busy), 0);
        chk("clr wrap1", 32'(if1.wrap), 0);

        // Async reset during STEP with count 4
        do_reset();
        req_v = 4'h1;
        dir_v = 4'h1;
        repeat (12) tick();
        chk("arst pre count", 32'(if0.count), 4);
        tick();
        chk("arst gnt", 32'(if0.gnt), 1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst count0", 32'(if0.count), 0);
        chk("arst count1", 32'(if1.count), 0);
        chk("arst gnt0",   32'(if0.gnt),   0);
        chk("arst busy",   32'(if0.busy),  0);
        req_v = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst first gnt", 32'(if0.gnt),    1);
        chk("arst first id",  32'(if0.gnt_id), 0);
        tick();
        chk("arst step count", 32'(if0.count), 1);

        // Randomised traffic against the reference model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_v = 4'($urandom);
            dir_v = 4'($urandom);
            clr_v = ($urandom_range(0, 15) == 0);
            tick();
            check_model(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
